// File: rtl/merge_arbiter.sv
// rtl/merge_arbiter.sv - packet-granular round-robin arbiter feeding a one-entry PE merge slot
//
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   req_data_i      N flits, port i at [i*`DW +: `DW], type in the top two bits
//   req_valid_i     per-port valid
//   req_ready_o     per-port ready (only the winner / granted port is ever ready)
//   merge_data_o    registered output slot flit
//   merge_valid_o   registered output slot valid
//   merge_ready_i   PE merge port ready
//   grant_o         one-hot locked port, zero while idle
//   err_o           sticky framing error, cleared by err_clr_i (a new error wins)
//   stall_o         locked packet has made no progress for STALL_MAX cycles
//   err_clr_i       clears err_o

`ifndef DW
`define DW 16
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef BODY
`define BODY 2'b10
`endif
`ifndef TAIL
`define TAIL 2'b11
`endif

module merge_arbiter #(
  parameter int N         = 4,
  parameter int STALL_MAX = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N*`DW-1:0]  req_data_i,
  input  logic [N-1:0]      req_valid_i,
  output logic [N-1:0]      req_ready_o,
  output logic [`DW-1:0]    merge_data_o,
  output logic              merge_valid_o,
  input  logic              merge_ready_i,
  output logic [N-1:0]      grant_o,
  output logic              err_o,
  output logic              stall_o,
  input  logic              err_clr_i
);

  localparam int DW = `DW;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(STALL_MAX + 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [DW-1:0] merge_data_q, merge_data_d;
  logic          merge_valid_q, merge_valid_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          err_q, err_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;

  logic [DW-1:0] port_flit [N];
  logic [N-1:0]  head_req;
  logic [N-1:0]  stray_req;

  // Per-port flit decode: a HEAD makes a port eligible, a BODY/TAIL seen
  // while idle is a framing error.
  always_comb begin
    head_req  = '0;
    stray_req = '0;
    for (int i = 0; i < N; i++) begin
      port_flit[i] = req_data_i[i*DW +: DW];
      head_req[i]  = req_valid_i[i] && (port_flit[i][DW-1:DW-2] == `HEAD);
      stray_req[i] = req_valid_i[i] && ((port_flit[i][DW-1:DW-2] == `BODY) ||
                                        (port_flit[i][DW-1:DW-2] == `TAIL));
    end
  end

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW:0]   scan_sum;
  logic [IW-1:0] scan_idx;

  // Round-robin scan rr_ptr, rr_ptr+1, ... wrapping modulo N (N need not be
  // a power of two, hence the explicit wrap).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < N; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (scan_sum >= (IW+1)'(N)) begin
        scan_sum = scan_sum - (IW+1)'(N);
      end
      scan_idx = scan_sum[IW-1:0];
      if (!win_found && head_req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  logic          slot_free;
  logic          xfer;
  logic [DW-1:0] xfer_flit;
  logic          err_set;
  logic [N-1:0]  ready;

  always_comb begin
    slot_free   = !merge_valid_q || merge_ready_i;
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    stall_cnt_d = stall_cnt_q;
    ready       = '0;
    xfer        = 1'b0;
    xfer_flit   = '0;
    err_set     = 1'b0;

    case (state_q)
      IDLE: begin
        err_set     = |stray_req;
        stall_cnt_d = '0;
        if (win_found && slot_free) begin
          ready[win_idx]   = 1'b1;
          xfer             = 1'b1;
          xfer_flit        = port_flit[win_idx];
          state_d          = LOCKED;
          gnt_d            = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
        end
      end
      LOCKED: begin
        ready[gnt_q] = slot_free;
        xfer_flit    = port_flit[gnt_q];
        xfer         = slot_free && req_valid_i[gnt_q];
        if (xfer) begin
          stall_cnt_d = '0;
          // A second HEAD inside a packet is passed through but flagged.
          if (xfer_flit[DW-1:DW-2] == `HEAD) begin
            err_set = 1'b1;
          end
          if (xfer_flit[DW-1:DW-2] == `TAIL) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = (gnt_q == IW'(N-1)) ? '0 : gnt_q + 1'b1;
          end
        end else if (stall_cnt_q != CW'(STALL_MAX)) begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Output slot: load on transfer, drain when the PE takes it, otherwise
    // hold so the flit stays stable under backpressure.
    merge_data_d  = merge_data_q;
    merge_valid_d = merge_valid_q;
    if (xfer) begin
      merge_data_d  = xfer_flit;
      merge_valid_d = 1'b1;
    end else if (merge_ready_i) begin
      merge_valid_d = 1'b0;
    end

    err_d = err_set || (err_q && !err_clr_i);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      rr_ptr_q      <= '0;
      merge_data_q  <= '0;
      merge_valid_q <= 1'b0;
      grant_q       <= '0;
      err_q         <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      rr_ptr_q      <= rr_ptr_d;
      merge_data_q  <= merge_data_d;
      merge_valid_q <= merge_valid_d;
      grant_q       <= grant_d;
      err_q         <= err_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign req_ready_o   = ready;
  assign merge_data_o  = merge_data_q;
  assign merge_valid_o = merge_valid_q;
  assign grant_o       = grant_q;
  assign err_o         = err_q;
  assign stall_o       = (stall_cnt_q == CW'(STALL_MAX));

endmodule

// File: tb/tb_merge_arbiter.sv
// tb/tb_merge_arbiter.sv - self-checking bench for merge_arbiter

`ifndef DW
`define DW 16
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef BODY
`define BODY 2'b10
`endif
`ifndef TAIL
`define TAIL 2'b11
`endif

module tb_merge_arbiter;
  localparam int N    = 4;
  localparam int SMAX = 4;
  localparam int DW   = `DW;
  localparam logic [1:0] T_HEAD = `HEAD;
  localparam logic [1:0] T_BODY = `BODY;
  localparam logic [1:0] T_TAIL = `TAIL;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   merge_data;
  logic            merge_valid;
  logic            merge_ready = 1'b1;
  logic [N-1:0]    grant;
  logic            err;
  logic            stall;
  logic            err_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  merge_arbiter #(.N(N), .STALL_MAX(SMAX)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_data_i   (req_data),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .merge_data_o (merge_data),
    .merge_valid_o(merge_valid),
    .merge_ready_i(merge_ready),
    .grant_o      (grant),
    .err_o        (err),
    .stall_o      (stall),
    .err_clr_i    (err_clr)
  );

  // Reference model state: lock owner (-1 = idle), rotation pointer,
  // output slot, sticky error and no-progress counter.
  int            m_lock;
  int            m_rr;
  int            m_stall;
  logic          m_mv;
  logic [DW-1:0] m_md;
  logic          m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pflit(input int p);
    return req_data[p*DW +: DW];
  endfunction

  function automatic logic [1:0] ptype(input int p);
    logic [DW-1:0] f;
    f = pflit(p);
    return f[DW-1:DW-2];
  endfunction

  task automatic drive(input int p, input logic v, input logic [1:0] t, input logic [13:0] pay);
    req_valid[p] = v;
    req_data[p*DW +: DW] = {t, pay};
  endtask

  task automatic model_reset();
    m_lock = -1; m_rr = 0; m_stall = 0; m_mv = 1'b0; m_md = '0; m_err = 1'b0;
  endtask

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    logic free;
    int p;
    r = '0;
    free = !m_mv || merge_ready;
    if (m_lock < 0) begin
      for (int k = 0; k < N; k++) begin
        p = (m_rr + k) % N;
        if (req_valid[p] && ptype(p) == T_HEAD) begin
          r[p] = free;
          break;
        end
      end
    end else begin
      r[m_lock] = free;
    end
    return r;
  endfunction

  task automatic model_check();
    logic [N-1:0] eg;
    eg = '0;
    if (m_lock >= 0) eg[m_lock] = 1'b1;
    chk("mdl_ready", req_ready, model_ready());
    chk("mdl_mvalid", merge_valid, m_mv);
    chk("mdl_mdata", merge_data, m_md);
    chk("mdl_grant", grant, eg);
    chk("mdl_err", err, m_err);
    chk("mdl_stall", stall, m_stall == SMAX);
  endtask

  task automatic model_step();
    logic [N-1:0] r;
    int x;
    logic set;
    r = model_ready();
    x = -1;
    set = 1'b0;
    for (int p = 0; p < N; p++) if (r[p] && req_valid[p]) x = p;
    if (m_lock < 0) begin
      for (int p = 0; p < N; p++)
        if (req_valid[p] && (ptype(p) == T_BODY || ptype(p) == T_TAIL)) set = 1'b1;
    end
    if (x >= 0) begin
      m_md = pflit(x);
      m_mv = 1'b1;
      m_stall = 0;
      if (m_lock < 0) begin
        m_lock = x;
      end else begin
        if (ptype(x) == T_HEAD) set = 1'b1;
        if (ptype(x) == T_TAIL) begin
          m_rr = (m_lock + 1) % N;
          m_lock = -1;
        end
      end
    end else begin
      if (merge_ready) m_mv = 1'b0;
      if (m_lock >= 0 && m_stall < SMAX) m_stall++;
    end
    m_err = set ? 1'b1 : (err_clr ? 1'b0 : m_err);
  endtask

  task automatic finish_cycle();
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    finish_cycle();
  endtask

  typedef struct {
    logic [N-1:0]    vld;
    logic [N*DW-1:0] data;
    logic            mrdy;
    logic [N-1:0]    e_rdy;
    logic            e_mv;
    logic [DW-1:0]   e_md;
    logic [N-1:0]    e_gnt;
    logic            e_err;
  } vec_t;

  vec_t tv [8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] outq[$];
    logic [N-1:0]  acc;
    logic [DW-1:0] expf;
    int            s0, s2, s3, idle_cnt;
    int            exp_p [8];
    int            exp_s [8];
    logic          quiet;

    // Port 1 packet H/B/T, then ports 0,2,3 offer HEADs: rr_ptr=2 picks port 2.
    tv[0] = '{vld:4'b0010, data:64'h0000_0000_4011_0000, mrdy:1'b1, e_rdy:4'b0010, e_mv:1'b0, e_md:16'h0000, e_gnt:4'b0000, e_err:1'b0};
    tv[1] = '{vld:4'b0010, data:64'h0000_0000_8022_0000, mrdy:1'b1, e_rdy:4'b0010, e_mv:1'b1, e_md:16'h4011, e_gnt:4'b0010, e_err:1'b0};
    tv[2] = '{vld:4'b0010, data:64'h0000_0000_C033_0000, mrdy:1'b1, e_rdy:4'b0010, e_mv:1'b1, e_md:16'h8022, e_gnt:4'b0010, e_err:1'b0};
    tv[3] = '{vld:4'b0000, data:64'h0,                   mrdy:1'b1, e_rdy:4'b0000, e_mv:1'b1, e_md:16'hC033, e_gnt:4'b0000, e_err:1'b0};
    tv[4] = '{vld:4'b0000, data:64'h0,                   mrdy:1'b1, e_rdy:4'b0000, e_mv:1'b0, e_md:16'hC033, e_gnt:4'b0000, e_err:1'b0};
    tv[5] = '{vld:4'b1101, data:64'h4066_4055_0000_4044, mrdy:1'b1, e_rdy:4'b0100, e_mv:1'b0, e_md:16'hC033, e_gnt:4'b0000, e_err:1'b0};
    tv[6] = '{vld:4'b1101, data:64'h4066_C077_0000_4044, mrdy:1'b1, e_rdy:4'b0100, e_mv:1'b1, e_md:16'h4055, e_gnt:4'b0100, e_err:1'b0};
    tv[7] = '{vld:4'b0000, data:64'h0,                   mrdy:1'b1, e_rdy:4'b0000, e_mv:1'b1, e_md:16'hC077, e_gnt:4'b0000, e_err:1'b0};

    exp_p = '{0, 0, 2, 2, 0, 0, 2, 2};
    exp_s = '{0, 1, 0, 1, 2, 3, 2, 3};

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mvalid", merge_valid, 1'b0);
    chk("rst_mdata", merge_data, 16'h0);
    chk("rst_grant", grant, 4'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_ready", req_ready, 4'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Table-driven single packet and rotation
    for (int i = 0; i < 8; i++) begin
      req_valid = tv[i].vld;
      req_data = tv[i].data;
      merge_ready = tv[i].mrdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), req_ready, tv[i].e_rdy);
      chk($sformatf("tbl%0d_mvalid", i), merge_valid, tv[i].e_mv);
      chk($sformatf("tbl%0d_mdata", i), merge_data, tv[i].e_md);
      chk($sformatf("tbl%0d_grant", i), grant, tv[i].e_gnt);
      chk($sformatf("tbl%0d_err", i), err, tv[i].e_err);
      finish_cycle();
    end

    // Round-robin: ports 0 and 2 stream 2-flit packets
    s0 = 0; s2 = 0; idle_cnt = 0;
    outq.delete();
    for (int c = 0; c < 10; c++) begin
      drive(0, c < 8, (s0 % 2 == 0) ? T_HEAD : T_TAIL, 14'(s0));
      drive(2, c < 8, (s2 % 2 == 0) ? T_HEAD : T_TAIL, 14'(512 + s2));
      @(negedge clk);
      if (merge_valid && merge_ready) outq.push_back(merge_data);
      if (c < 8 && grant == '0) idle_cnt++;
      acc = req_ready & req_valid;
      finish_cycle();
      if (acc[0]) s0++;
      if (acc[2]) s2++;
    end
    chk("rr_count", outq.size(), 8);
    chk("rr_idle_gaps", idle_cnt, 4);
    for (int i = 0; i < 8; i++) begin
      expf = {(exp_s[i] % 2 == 0) ? T_HEAD : T_TAIL, 14'(exp_p[i] * 256 + exp_s[i])};
      if (i < outq.size()) chk($sformatf("rr_flit%0d", i), outq[i], expf);
    end

    // Backpressure on port 3
    s3 = 0;
    outq.delete();
    for (int c = 0; c < 12; c++) begin
      drive(3, s3 < 3, (s3 == 0) ? T_HEAD : ((s3 == 1) ? T_BODY : T_TAIL), 14'(768 + s3));
      merge_ready = !(c >= 1 && c <= 5);
      @(negedge clk);
      if (c >= 1 && c <= 5) begin
        chk($sformatf("bp_ready_c%0d", c), req_ready[3], 1'b0);
        chk($sformatf("bp_hold_c%0d", c), merge_data, 16'h4300);
      end
      if (merge_valid && merge_ready) outq.push_back(merge_data);
      acc = req_ready & req_valid;
      finish_cycle();
      if (acc[3]) s3++;
    end
    merge_ready = 1'b1;
    chk("bp_count", outq.size(), 3);
    if (outq.size() > 0) chk("bp_head", outq[0], 16'h4300);
    if (outq.size() > 1) chk("bp_body", outq[1], 16'h8301);
    if (outq.size() > 2) chk("bp_tail", outq[2], 16'hC302);

    // Stall on port 0 with STALL_MAX=4
    for (int c = 0; c < 11; c++) begin
      if (c == 0) drive(0, 1'b1, T_HEAD, 14'h101);
      else if (c == 7) drive(0, 1'b1, T_BODY, 14'h102);
      else if (c == 8) drive(0, 1'b1, T_TAIL, 14'h103);
      else drive(0, 1'b0, T_HEAD, 14'h0);
      @(negedge clk);
      if (c >= 1 && c <= 8) chk($sformatf("stall_c%0d", c), stall, (c >= 5 && c <= 7));
      finish_cycle();
    end

    // Framing error and clear priority
    drive(2, 1'b1, T_BODY, 14'h2AA);
    @(negedge clk);
    chk("fe_ready", req_ready, 4'b0);
    finish_cycle();
    drive(2, 1'b0, T_BODY, 14'h0);
    err_clr = 1'b1;
    @(negedge clk);
    chk("fe_set", err, 1'b1);
    finish_cycle();
    err_clr = 1'b0;
    @(negedge clk);
    chk("fe_clr", err, 1'b0);
    finish_cycle();
    drive(2, 1'b1, T_BODY, 14'h2AB);
    err_clr = 1'b1;
    cycle();
    drive(2, 1'b0, T_BODY, 14'h0);
    err_clr = 1'b0;
    @(negedge clk);
    chk("fe_coincide", err, 1'b1);
    finish_cycle();
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    @(negedge clk);
    chk("fe_clr2", err, 1'b0);
    finish_cycle();

    // Reset mid-packet
    drive(1, 1'b1, T_HEAD, 14'h111);
    cycle();
    drive(1, 1'b1, T_BODY, 14'h112);
    cycle();
    rstn = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_mvalid", merge_valid, 1'b0);
    chk("mid_rst_mdata", merge_data, 16'h0);
    chk("mid_rst_grant", grant, 4'b0);
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_ready", req_ready, 4'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    drive(0, 1'b1, T_HEAD, 14'h001);
    @(negedge clk);
    chk("mid_rst_arb", req_ready, 4'b0001);
    finish_cycle();
    drive(0, 1'b1, T_TAIL, 14'h002);
    drive(1, 1'b0, T_BODY, 14'h0);
    @(negedge clk);
    chk("mid_rst_err", err, 1'b1);
    chk("mid_rst_grant0", grant, 4'b0001);
    finish_cycle();
    drive(0, 1'b0, T_HEAD, 14'h0);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    cycle();

    // Randomized traffic against the model, alternating busy and quiet phases
    for (int c = 0; c < 2000; c++) begin
      quiet = ((c / 200) % 2) == 1;
      for (int p = 0; p < N; p++) begin
        req_valid[p] = quiet ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 7) < 6);
        req_data[p*DW +: DW] = DW'($urandom);
      end
      merge_ready = ($urandom_range(0, 3) != 0);
      err_clr = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/merge_arbiter.md
Name: merge_arbiter

Overview:
- Shares one PE merge input among N upstream merge streams.
- Grants a whole packet (HEAD through TAIL) to one requester at a time and rotates the grant round-robin between packets.
- Drives a one-entry registered output slot that feeds the PE merge port (merge_data_i / merge_valid_i / merge_ready_o).
- Flags framing errors and stalled packets for deadlock debug in the virtual network.

Parameters:
- N, 4, number of requester ports (2..8).
- STALL_MAX, 64, number of consecutive locked cycles with no flit accepted before stall_o asserts (≥1).
- Flit width is `DW. The flit type is the field [`DW-1:`DW-2], compared against `HEAD, `BODY and `TAIL.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_data_i  in  N*`DW  flit from port i, packed at [i*`DW +: `DW]
- req_valid_i  in  N  per-port valid
- req_ready_o  out  N  per-port ready
- merge_data_o  out  `DW  flit to PE merge port
- merge_valid_o  out  1  output slot valid
- merge_ready_i  in  1  PE merge ready
- grant_o  out  N  one-hot granted port; all zero in IDLE
- err_o  out  1  sticky framing-error flag
- stall_o  out  1  locked-packet stall indicator
- err_clr_i  in  1  clears err_o

Behaviour:
- Reset (asynchronous, rstn=0):
  - State = IDLE, rr_ptr = 0, slot empty.
  - merge_valid_o = 0, merge_data_o = 0, grant_o = 0, err_o = 0, stall_o = 0, stall counter = 0.
  - Reset mid-packet discards the slot and any packet in progress. There is no replay.
- Slot accept condition: slot_free = !merge_valid_o | merge_ready_i. A flit transfers from the granted port when req_valid & req_ready.
  - On transfer: merge_data_o <= flit and merge_valid_o <= 1, one cycle later.
  - No transfer and merge_ready_i=1: merge_valid_o <= 0.
  - Latency is 1 cycle. Throughput is 1 flit/cycle under continuous ready.
- IDLE:
  - Eligible ports have valid=1 and type=`HEAD.
  - The winner is the first eligible port scanning rr_ptr, rr_ptr+1, … mod N.
  - If slot_free: req_ready_o[winner]=1, the HEAD transfers, the state becomes LOCKED(winner), and grant_o is one-hot from the next cycle.
  - If no port is eligible, all req_ready_o are 0.
  - A port presenting `BODY or `TAIL in IDLE is held with ready=0 and sets err_o.
- LOCKED(g):
  - req_ready_o[g] = slot_free. All other ready bits are 0.
  - `BODY keeps the lock.
  - `TAIL transfer: state goes to IDLE and rr_ptr <= (g+1) mod N.
  - The next HEAD can therefore transfer in the cycle after the TAIL (one-cycle arbitration bubble per packet).
  - A `HEAD from port g while LOCKED transfers, keeps the lock, and sets err_o.
- err_o:
  - Sticky; cleared by err_clr_i.
  - If a set event and err_clr_i occur in the same cycle, set wins.
- Stall counter:
  - Counts cycles in LOCKED with no transfer, saturating at STALL_MAX.
  - Resets to 0 on any transfer or on return to IDLE.
  - stall_o = (counter == STALL_MAX).
- Output stability: while merge_valid_o=1 and merge_ready_i=0, merge_data_o must not change.
- Non-granted req_data_i is ignored, X allowed.

Test Plan:
- Single packet: port 1 sends HEAD(0x11), BODY(0x22), TAIL(0x33) with merge_ready_i=1.
  - merge_data_o shows the three flits on cycles t+1..t+3.
  - grant_o=0010 while locked; rr_ptr=2 afterwards.
- Round-robin fairness: ports 0 and 2 each hold a continuous stream of 2-flit packets.
  - Output packet order is 0,2,0,2.
  - No flits interleave within a packet.
  - A one-cycle IDLE gap appears between packets.
- Backpressure: port 3 packet with merge_ready_i=0 for 5 cycles after the HEAD.
  - merge_data_o holds HEAD and req_ready_o[3]=0 throughout.
  - Flow resumes without loss when ready returns.
- Stall: STALL_MAX=4; port 0 sends HEAD, then req_valid_i[0]=0.
  - stall_o rises 4 cycles after the HEAD accept.
  - stall_o clears on the next BODY accept.
- Framing error: port 2 presents BODY while IDLE.
  - Port 2 is not readied and err_o=1.
  - err_clr_i pulse clears err_o; the flag remains set if a new error coincides with the clear.
- Reset mid-packet: rstn=0 after port 1 HEAD+BODY.
  - All outputs are 0 immediately.
  - After release, port 1 BODY is rejected and flags err_o; a fresh HEAD from port 0 is granted (rr_ptr=0).
